ram_arbiter: RTL and testbench

Two-requester controller that shares the single-port, byte-addressable RAM between the instruction-fetch port (read-only) and the data port (read/write). It arbitrates round-robin and sequences each word access through a fixed 3-state FSM. It drives the RAM's wr_en, addr and bidirectional data bus. It returns registered read data with a one-cycle ack pulse. It sits between the CPU core's fetch/LSU units and ram.

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram_arbiter_rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared sizes, FSM encodings and port IDs for the two-port RAM arbiter.
package ram_arbiter_pkg;

    localparam int ADDR_SIZE = 16;
    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

    function automatic logic misaligned(input logic addr_lsb, input logic check_en);
        return addr_lsb & check_en;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module ram_arbiter_rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_sel
);

    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_sel   = ARB_SEL_I;
        if (i_req && d_req) begin
            gnt_sel = ~last_grant;
        end else if (d_req) begin
            gnt_sel = ARB_SEL_D;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port byte-addressable RAM between a read-only fetch port
// and a read/write data port; every word access is IDLE -> ACCESS -> RESP.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_SIZE,
    parameter int DATA_W      = WORD_SIZE,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              gnt_valid;
    logic              gnt_sel;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_err;

    ram_arbiter_rr_arb2 u_rr_arb2 (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    assign gnt_addr = (gnt_sel == ARB_SEL_D) ? d_addr : i_addr;
    assign gnt_err  = misaligned(gnt_addr[0], ALIGN_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            last_q     <= ARB_SEL_D;
            sel_q      <= ARB_SEL_I;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            ram_addr_q <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wdata_q    <= wdata_d;
            ram_addr_q <= ram_addr_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wdata_d    = wdata_q;
        ram_addr_d = ram_addr_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    sel_d   = gnt_sel;
                    last_d  = gnt_sel;
                    err_d   = gnt_err;
                    wdata_d = d_wdata;
                    if (gnt_err) begin
                        state_d = ARB_RESP;
                    end else begin
                        // wr_en and the address are registered on entry so the
                        // bus drive and the strobe change on the same edge.
                        state_d    = ARB_ACCESS;
                        wr_en_d    = (gnt_sel == ARB_SEL_D) & d_we;
                        ram_addr_d = gnt_addr;
                    end
                end
            end
            ARB_ACCESS: begin
                if (!wr_en_q) begin
                    if (sel_q == ARB_SEL_D) begin
                        d_rdata_d = ram_data;
                    end else begin
                        i_rdata_d = ram_data;
                    end
                end
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign i_ack     = (state_q == ARB_RESP) && (sel_q == ARB_SEL_I);
    assign d_ack     = (state_q == ARB_RESP) && (sel_q == ARB_SEL_D);
    assign i_err     = i_ack & err_q;
    assign d_err     = d_ack & err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign ram_wr_en = wr_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = wr_en_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte RAM on the shared bus, a transaction-timing
// reference model compared every cycle, and directed literal checks.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        ram_wr_en;
    logic [15:0] ram_addr;
    wire  [15:0] ram_data;

    int checks = 0;
    int errors = 0;

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    always #5 clk = ~clk;

    // RAM: little-endian word at addr, addr+1; drives the bus only when not writing
    logic [7:0]  mem [0:65535] = '{default: 8'h00};
    logic [15:0] ram_addr_p1;
    assign ram_addr_p1 = ram_addr + 16'd1;
    assign ram_data = ram_wr_en ? 16'hzzzz : {mem[ram_addr_p1], mem[ram_addr]};
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr]    <= ram_data[7:0];
            mem[ram_addr_p1] <= ram_data[15:8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a grant at cycle g does its memory op in g+1 and acks in
    // g+2 (misaligned: no memory op, ack in g+1); the next grant is at ack+1.
    logic [7:0]  model_mem [0:65535] = '{default: 8'h00};
    int          cyc = 0;
    int          free_at = 0;
    int          acc_cyc = -1;
    int          ack_cyc = -1;
    logic        m_last = 1'b1;
    logic        m_sel = 1'b0;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_irdata = '0;
    logic [15:0] m_drdata = '0;
    logic [15:0] e_addr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      = 0;
            free_at  = 0;
            acc_cyc  = -1;
            ack_cyc  = -1;
            m_last   = 1'b1;
            m_sel    = 1'b0;
            m_irdata = '0;
            m_drdata = '0;
            e_addr   = '0;
        end else begin
            if (cyc == acc_cyc) begin
                if (m_we) begin
                    model_mem[m_addr]         = m_wdata[7:0];
                    model_mem[m_addr + 16'd1] = m_wdata[15:8];
                end else if (m_sel) begin
                    m_drdata = {model_mem[m_addr + 16'd1], model_mem[m_addr]};
                end else begin
                    m_irdata = {model_mem[m_addr + 16'd1], model_mem[m_addr]};
                end
            end
            if (cyc >= free_at && (i_req || d_req)) begin
                m_sel   = (i_req && d_req) ? !m_last : d_req;
                m_last  = m_sel;
                m_we    = m_sel & d_we;
                m_addr  = m_sel ? d_addr : i_addr;
                m_wdata = d_wdata;
                m_err   = m_addr[0];
                if (m_err) begin
                    acc_cyc = -1;
                    ack_cyc = cyc + 1;
                end else begin
                    acc_cyc = cyc + 1;
                    ack_cyc = cyc + 2;
                end
                free_at = ack_cyc + 1;
            end
            cyc++;
            if (cyc == acc_cyc) e_addr = m_addr;
        end
    end

    logic e_wr, e_iack, e_dack;
    always @(negedge clk) begin
        e_wr   = (cyc == acc_cyc) && m_we;
        e_iack = (cyc == ack_cyc) && !m_sel;
        e_dack = (cyc == ack_cyc) && m_sel;
        check("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
        check("ram_addr",  32'(ram_addr),  32'(e_addr));
        check("i_ack",     32'(i_ack),     32'(e_iack));
        check("d_ack",     32'(d_ack),     32'(e_dack));
        check("i_err",     32'(i_err),     32'(e_iack && m_err));
        check("d_err",     32'(d_err),     32'(e_dack && m_err));
        check("i_rdata",   32'(i_rdata),   32'(m_irdata));
        check("d_rdata",   32'(d_rdata),   32'(m_drdata));
        if (e_wr) check("ram_data_wr", 32'(ram_data), 32'(m_wdata));
    end

    task automatic access(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (port ? d_ack : i_ack) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (port) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int ia[$];
    int da[$];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_i_ack",   32'(i_ack),     32'h0);
        check("rst_d_rdata", 32'(d_rdata),   32'h0);
        check("rst_wr_en",   32'(ram_wr_en), 32'h0);
        check("rst_addr",    32'(ram_addr),  32'h0);

        access(1'b1, 1'b1, 16'h0010, 16'hBEEF, 2, "dwr");
        check("dwr_err",  32'(d_err),    32'h0);
        check("mem_10",   32'(mem[16]),  32'hEF);
        check("mem_11",   32'(mem[17]),  32'hBE);

        @(posedge clk); #1;
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 2, "ird");
        check("ird_data", 32'(i_rdata), 32'hBEEF);
        check("ird_err",  32'(i_err),   32'h0);

        // Tie after reset: fetch wins first, then strict alternation.
        do_reset();
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (i_ack) ia.push_back(k);
            if (d_ack) da.push_back(k);
        end
        i_req = 1'b0; d_req = 1'b0;
        check("tie_ni",  32'(ia.size()), 32'd2);
        check("tie_nd",  32'(da.size()), 32'd2);
        check("tie_i0",  32'(ia[0]), 32'd2);
        check("tie_d0",  32'(da[0]), 32'd5);
        check("tie_i1",  32'(ia[1]), 32'd8);
        check("tie_d1",  32'(da[1]), 32'd11);
        check("tie_ird", 32'(i_rdata), 32'hBEEF);
        check("tie_drd", 32'(d_rdata), 32'hBEEF);

        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h0011, 16'h0000, 1, "dmis");
        check("dmis_err",  32'(d_err),     32'h1);
        check("dmis_rd",   32'(d_rdata),   32'hBEEF);
        check("dmis_wren", 32'(ram_wr_en), 32'h0);
        @(posedge clk); #1;
        access(1'b0, 1'b0, 16'h0013, 16'h0000, 1, "imis");
        check("imis_err",  32'(i_err),   32'h1);

        // Reset lands inside the ACCESS cycle of a write.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        @(posedge clk); #1;
        check("rstw_pre_wren", 32'(ram_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw_wren",  32'(ram_wr_en), 32'h0);
        check("rstw_addr",  32'(ram_addr),  32'h0);
        check("rstw_ack",   32'(d_ack),     32'h0);
        check("rstw_drd",   32'(d_rdata),   32'h0);
        check("rstw_ird",   32'(i_rdata),   32'h0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        check("rstw_mem20", 32'(mem[32]), 32'h00);
        check("rstw_mem21", 32'(mem[33]), 32'h00);
        rst_n = 1'b1;

        access(1'b1, 1'b1, 16'h0020, 16'h5A5A, 2, "b2b_wr");
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 3, "b2b_rd");
        check("b2b_data",  32'(d_rdata), 32'h5A5A);
        check("b2b_mem20", 32'(mem[32]), 32'h5A);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
